mux_arb_reg: RTL
================

// Module: mux_arb_reg
// PURPOSE
//  Parametrised N-input, W-bit selector with a registered output and valid/ready handshake.
//  Successor to the fixed 4x1 5-bit combinational mux used in datapath operand/writeback selection.
//  Mode 0 selects the port given by sel. Mode 1 arbitrates round-robin among the valid inputs.
//  The one-entry output register holds its data under back-pressure, so the block can sit
//  between pipeline stages.
// PARAMETERS
//  WIDTH      5   data width per port, >=1
//  NUM_PORTS  4   number of input ports, >=2 (need not be a power of two)
//  SEL_W      $clog2(NUM_PORTS)  select/port-index width (derived; do not override)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous, active-low reset
//  in_data    in   NUM_PORTS*WIDTH    port i data = in_data[i*WIDTH +: WIDTH]
//  in_valid   in   NUM_PORTS          port i has data
//  in_ready   out  NUM_PORTS          port i data accepted this cycle (valid&ready = transfer)
//  mode       in   1                  0 = fixed select by sel, 1 = round-robin
//  sel        in   SEL_W              port index used in mode 0
//  out_data   out  WIDTH              registered selected data
//  out_port   out  SEL_W              index of the port that supplied out_data
//  out_valid  out  1                  out_data/out_port are valid
//  out_ready  in   1                  downstream accepts out_data
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream):
//   - out_valid=0, out_data=0, out_port=0.
//   - last_grant=NUM_PORTS-1, so port 0 has first priority after reset.
//   - Reset mid-transfer discards the held entry; no partial state survives.
//  load_en = !out_valid | out_ready (register empty or being drained this cycle).
//  Grant (combinational, from current inputs):
//   - mode 0: grant=sel, gnt_ok=in_valid[sel]. If sel>=NUM_PORTS then gnt_ok=0 (no grant, no X).
//   - mode 1: first i with in_valid[i]=1, searching (last_grant+1) .. wrapping modulo NUM_PORTS.
//     gnt_ok=|in_valid.
//  in_ready[i] = load_en & gnt_ok & (grant==i). At most one bit is set (one-hot or zero).
//   in_ready depends combinationally on out_ready. This path is accepted; no ready->valid loop.
//  On a clk edge with load_en:
//   - If gnt_ok: out_data<=selected data, out_port<=grant, out_valid<=1.
//     In mode 1 only, also last_grant<=grant.
//   - Else out_valid<=0 (out_data/out_port keep old values).
//  Without load_en (out_valid & !out_ready): out_data, out_port and out_valid are held exactly,
//   and all in_ready=0.
//  Latency: input transfer at edge k -> out_valid at k+1. Full throughput, 1 word/cycle,
//   when out_ready=1.
//  last_grant only updates on a mode-1 transfer. Mode-0 transfers leave it unchanged.
//  mode/sel changes take effect on the next arbitration; they never alter a held output.
//  Round-robin fairness: with all ports valid and out_ready=1, grants cycle 0,1,..,N-1,0...
//   Any valid port waits at most NUM_PORTS-1 transfers.
// TESTING (WIDTH=5, NUM_PORTS=4 unless stated)
//  1. Reset & mode 0, one port per sel:
//     - hold rst_n=0 -> out_valid=0, out_data=0.
//     - release; mode=0, all valid, data {3:5'h1F,2:5'h0A,1:5'h15,0:5'h03}, out_ready=1.
//     - sel=0,1,2,3 on successive cycles -> out_data 03,15,0A,1F one cycle later, out_port matches.
//  2. Back-pressure:
//     - out_valid=1 with 5'h15; set out_ready=0 for 3 cycles while inputs change.
//     - out_data stays 5'h15 and in_ready=0 throughout.
//     - out_ready=1 -> the next word loads on the following edge.
//  3. Round-robin:
//     - mode=1, all four valid, out_ready=1 -> out_port sequence 0,1,2,3,0,1.
//     - then only ports 1 and 3 valid -> alternates 1,3,1,3.
//  4. Sparse/empty:
//     - mode=1, only port 2 valid for one cycle -> one transfer, then out_valid=0 the next cycle.
//     - in_valid=0 -> out_valid stays 0 and out_data holds its last value.
//  5. NUM_PORTS=3: mode 0 with sel=2'b11 and all valid -> in_ready=3'b000, out_valid=0.
//     - Round-robin over 3 ports wraps 0,1,2,0.
//  6. Mid-operation events:
//     - assert rst_n=0 asynchronously while out_valid=1 -> out_valid=0 immediately.
//     - after release, port 0 wins first.
//     - switch mode 1->0 while output is held -> held data is unchanged.

Source files
------------

// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: N input ports with valid/ready plus one registered output.
// The slave modport is the selector's view; master is the view of whoever drives it.
interface mux_arb_reg_if #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned NUM_PORTS = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS*WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]       in_valid;
  logic [NUM_PORTS-1:0]       in_ready;
  logic                       mode;
  logic [SEL_W-1:0]           sel;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_port;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_port, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_port, out_valid
  );
endinterface

// File: rtl/mux_arb_reg.sv
// N-input, W-bit selector (fixed select or round-robin) feeding a one-entry output register
// with valid/ready handshake; the register holds its contents under back-pressure.
module mux_arb_reg #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned NUM_PORTS = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux_arb_reg_if.slave     bus
);
  localparam int unsigned SEL_W = $clog2(NUM_PORTS);
  localparam logic [SEL_W-1:0] LastPort = SEL_W'(NUM_PORTS - 1);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_port_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] last_grant_q;

  logic             load_en;
  logic             fix_ok;
  logic             rr_ok;
  logic [SEL_W-1:0] rr_grant;
  logic             gnt_ok;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !out_valid_q || bus.out_ready;

  // Out-of-range sel never matches any port, so it yields no grant rather than an X select.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (bus.sel == SEL_W'(i)) begin
        fix_ok = bus.in_valid[i];
      end
    end
  end

  // Two passes: ports above last_grant first, then wrap around to the rest.
  always_comb begin
    rr_ok    = 1'b0;
    rr_grant = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!rr_ok && bus.in_valid[i] && (SEL_W'(i) > last_grant_q)) begin
        rr_ok    = 1'b1;
        rr_grant = SEL_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!rr_ok && bus.in_valid[i] && (SEL_W'(i) <= last_grant_q)) begin
        rr_ok    = 1'b1;
        rr_grant = SEL_W'(i);
      end
    end
  end

  always_comb begin
    if (bus.mode) begin
      grant  = rr_grant;
      gnt_ok = rr_ok;
    end else begin
      grant  = bus.sel;
      gnt_ok = fix_ok;
    end
  end

  always_comb begin
    grant_data = '0;
    bus.in_ready = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data      = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = load_en && gnt_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_port_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= LastPort;
    end else if (load_en) begin
      if (gnt_ok) begin
        out_data_q  <= grant_data;
        out_port_q  <= grant;
        out_valid_q <= 1'b1;
        // Fixed-select transfers must not disturb the round-robin pointer.
        if (bus.mode) begin
          last_grant_q <= grant;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_port  = out_port_q;
  assign bus.out_valid = out_valid_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.in_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_port)));

endmodule
